// File: rtl/seg7_pkg.sv
// Shared definitions for the five-digit seven-segment scan driver.
//   - segment patterns (active-high, bit order {g,f,e,d,c,b,a})
//   - digit count, "no decimal point" marker
//   - digit-set and latched-frame types
package seg7_pkg;

  localparam int NUM_DIGITS = 5;
  localparam logic [2:0] DP_NONE = 3'd7;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Index 0 = ones ... index 4 = ten-thousands.
  typedef logic [NUM_DIGITS-1:0][3:0] digits_t;

  // One complete set of things shown in a frame.
  typedef struct packed {
    digits_t    digits;
    logic [2:0] dp_pos;
  } frame_data_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD-to-segment decoder.
//   code : 4-bit digit code (10..15 are error codes)
//   seg  : 7-bit active-high pattern {g,f,e,d,c,b,a}; error codes show "-"
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  always_comb begin
    unique case (code)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan5.sv
// Time-multiplexed five-digit seven-segment driver.
// Digits are captured into a shadow set on `load` and copied to the display
// set only at the frame wrap, so a frame never tears. Each slot starts with
// a GUARD-cycle all-off interval to prevent ghosting.
//   clk, rst        : clock, asynchronous active-high reset
//   load            : one-cycle strobe capturing digits and dp_pos
//   ten_thous..ones : BCD digits
//   dp_pos          : decimal point index (0 = ones, 5..7 = none)
//   blank_lz        : live leading-zero blanking enable
//   seg, dp         : segment / decimal point drive (registered)
//   dig             : one-hot digit enable, bit 0 = ones (registered)
//   frame           : one-cycle pulse after each frame wrap (registered)
module seg7_scan5
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int GUARD          = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] ten_thous,
  input  logic [3:0] thousands,
  input  logic [3:0] hundreds,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  input  logic [2:0] dp_pos,
  input  logic       blank_lz,
  output logic [6:0] seg,
  output logic       dp,
  output logic [4:0] dig,
  output logic       frame
);

  localparam int              PW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0]   PCNT_MAX = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0]   GUARD_W  = PW'(GUARD);
  localparam logic [2:0]      IDX_MAX  = 3'(NUM_DIGITS - 1);
  localparam logic [6:0]      SEG_OFF  = {7{SEG_ACTIVE_LOW}};
  localparam logic            DP_OFF   = SEG_ACTIVE_LOW;
  localparam logic [4:0]      DIG_OFF  = {5{DIG_ACTIVE_LOW}};
  localparam frame_data_t     DATA_RST = '{digits: '0, dp_pos: DP_NONE};

  if (SCAN_DIV < 2) begin : g_bad_scan_div
    $error("seg7_scan5: SCAN_DIV must be >= 2");
  end
  if (GUARD < 0 || GUARD >= SCAN_DIV) begin : g_bad_guard
    $error("seg7_scan5: GUARD must satisfy 0 <= GUARD < SCAN_DIV");
  end

  logic [PW-1:0] pcnt;
  logic [2:0]    idx;
  logic          slot_end;
  logic          wrap;

  assign slot_end = (pcnt == PCNT_MAX);
  assign wrap     = slot_end && (idx == IDX_MAX);

  // NOTE: sequential state is assigned with <= so every register samples
  // pre-edge values; mixing in = here creates simulation/synthesis races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt <= '0;
      idx  <= '0;
    end else if (slot_end) begin
      pcnt <= '0;
      idx  <= wrap ? 3'd0 : idx + 3'd1;
    end else begin
      pcnt <= pcnt + PW'(1);
    end
  end

  frame_data_t shadow;
  frame_data_t disp;

  // NOTE: these are a handful of flops, not a RAM, so they take a reset;
  // the display dp marker resets to "none" so nothing lights spuriously.
  // A load on the wrap edge leaves disp with the old shadow contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow <= DATA_RST;
      disp   <= DATA_RST;
    end else begin
      if (load) shadow <= '{digits: {ten_thous, thousands, hundreds, tens, ones},
                            dp_pos: dp_pos};
      if (wrap) disp <= shadow;
    end
  end

  // Leading-zero mask: a running AND of "is zero" from the top digit down.
  // Digits at or below a valid dp position are protected; ones is never masked.
  logic [NUM_DIGITS-1:0] blank_mask;
  logic                  zeros_above;
  logic                  dp_valid;

  // NOTE: every always_comb output gets a default before any conditional
  // logic, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    blank_mask  = '0;
    zeros_above = blank_lz;
    dp_valid    = (disp.dp_pos < 3'(NUM_DIGITS));
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zeros_above   = zeros_above && (disp.digits[k] == 4'd0);
      blank_mask[k] = zeros_above && !(dp_valid && (3'(k) <= disp.dp_pos));
    end
  end

  logic [6:0] dec_seg;
  logic [6:0] raw_seg;
  logic       in_guard;

  seg7_decode u_decode (
    .code (disp.digits[idx]),
    .seg  (dec_seg)
  );

  assign raw_seg  = blank_mask[idx] ? SEG_BLANK : dec_seg;
  assign in_guard = (pcnt < GUARD_W);

  // Polarity is applied with XOR against the "off" level as the last step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg   <= SEG_OFF;
      dp    <= DP_OFF;
      dig   <= DIG_OFF;
      frame <= 1'b0;
    end else begin
      frame <= wrap;
      if (in_guard) begin
        seg <= SEG_OFF;
        dp  <= DP_OFF;
        dig <= DIG_OFF;
      end else begin
        seg <= raw_seg ^ SEG_OFF;
        dp  <= (idx == disp.dp_pos) ^ DP_OFF;
        dig <= (5'd1 << idx) ^ DIG_OFF;
      end
    end
  end

endmodule
